lc_otp_prog_arb: RTL and testbench



---
 rtl/lc_otp_prog_arb.sv | 195 +++++++++++++++++++
 tb/tb_lc_otp_prog_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc_otp_prog_arb.sv
// Round-robin arbiter of NUM_REQ LC program requests onto one OTP program port, with timeout and escalation lockout.
// Latency: otp_req_o one cycle after grant, response one cycle after ack; requesters hold req_valid_i until the req_ready_o pulse.
module lc_otp_prog_arb #(
  parameter int NUM_REQ     = 2,
  parameter int STATE_W     = 320,
  parameter int CNT_W       = 384,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*STATE_W-1:0] req_state_i,
  input  logic [NUM_REQ*CNT_W-1:0]   req_count_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [1:0]                 rsp_status_o,
  output logic                       otp_req_o,
  output logic [STATE_W-1:0]         otp_state_o,
  output logic [CNT_W-1:0]           otp_count_o,
  input  logic                       otp_ack_i,
  input  logic                       otp_err_i,
  input  logic [3:0]                 lc_escalate_en_i,
  output logic                       busy_o,
  output logic                       locked_o,
  output logic                       spurious_ack_o
);

  localparam int         PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] LC_TX_OFF = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOCKED
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         esc_q1, esc_q2;
  logic               escalate;
  logic               tmo_expire;

  logic [NUM_REQ-1:0] gnt_oh, cur_oh;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic [STATE_W-1:0] state_sel;
  logic [CNT_W-1:0]   count_sel;

  logic               otp_req_d, latch;
  logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d;
  logic [1:0]         rsp_status_d;

  // Escalation input is asynchronous; anything other than OFF locks the arbiter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      esc_q1 <= LC_TX_OFF;
      esc_q2 <= LC_TX_OFF;
    end else begin
      esc_q1 <= lc_escalate_en_i;
      esc_q2 <= esc_q1;
    end
  end

  assign escalate = (esc_q2 != LC_TX_OFF);

  // Search channels above the pointer first, then wrap to the low ones.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = ptr_q;
    gnt_oh    = '0;
    cur_oh    = '0;
    state_sel = '0;
    count_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_vld && (i > int'(ptr_q)) && req_valid_i[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_vld && req_valid_i[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == PTR_W'(i));
      cur_oh[i] = (ptr_q == PTR_W'(i));
      if (gnt_oh[i]) begin
        state_sel = req_state_i[i*STATE_W +: STATE_W];
        count_sel = req_count_i[i*CNT_W +: CNT_W];
      end
    end
  end

  if (TIMEOUT_CYC > 0) begin : g_tmo
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        tmo_q <= '0;
      end else if (state_q == ST_IDLE && gnt_vld) begin
        tmo_q <= TMO_W'(TIMEOUT_CYC);
      end else if (state_q == ST_REQ && tmo_q != '0) begin
        tmo_q <= tmo_q - TMO_W'(1);
      end
    end

    // Expiry is flagged on the cycle the counter steps from 1 to 0.
    assign tmo_expire = (state_q == ST_REQ) && (tmo_q == TMO_W'(1));
  end else begin : g_no_tmo
    assign tmo_expire = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    otp_req_d    = otp_req_o;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_status_d = 2'b00;
    latch        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (escalate) begin
          state_d = ST_LOCKED;
        end else if (gnt_vld) begin
          latch       = 1'b1;
          req_ready_d = gnt_oh;
          otp_req_d   = 1'b1;
          ptr_d       = gnt_idx;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // Priority: escalation over ack, ack over timeout.
        if (escalate) begin
          rsp_valid_d  = cur_oh;
          rsp_status_d = 2'b11;
          otp_req_d    = 1'b0;
          state_d      = ST_LOCKED;
        end else if (otp_ack_i) begin
          rsp_valid_d  = cur_oh;
          rsp_status_d = {1'b0, otp_err_i};
          otp_req_d    = 1'b0;
          state_d      = ST_IDLE;
        end else if (tmo_expire) begin
          rsp_valid_d  = cur_oh;
          rsp_status_d = 2'b10;
          otp_req_d    = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        otp_req_d = 1'b0;
      end
      default: begin
        otp_req_d = 1'b0;
        state_d   = ST_LOCKED;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      ptr_q          <= PTR_W'(NUM_REQ - 1);
      otp_req_o      <= 1'b0;
      req_ready_o    <= '0;
      rsp_valid_o    <= '0;
      rsp_status_o   <= 2'b00;
      otp_state_o    <= '0;
      otp_count_o    <= '0;
      busy_o         <= 1'b0;
      locked_o       <= 1'b0;
      spurious_ack_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      otp_req_o      <= otp_req_d;
      req_ready_o    <= req_ready_d;
      rsp_valid_o    <= rsp_valid_d;
      rsp_status_o   <= rsp_status_d;
      busy_o         <= (state_d == ST_REQ);
      locked_o       <= (state_d == ST_LOCKED);
      spurious_ack_o <= spurious_ack_o | (otp_ack_i && (state_q != ST_REQ));
      if (latch) begin
        otp_state_o <= state_sel;
        otp_count_o <= count_sel;
      end
    end
  end

endmodule

// File: tb/tb_lc_otp_prog_arb.sv
// Randomized bench for lc_otp_prog_arb against a round-robin transaction model.
module tb_lc_otp_prog_arb;
  localparam int N   = 2;
  localparam int SW  = 64;
  localparam int CW  = 48;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*SW-1:0] req_state;
  logic [N*CW-1:0] req_count;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [1:0]      rsp_status;
  logic            otp_req, otp_ack, otp_err, busy, locked, spurious;
  logic [SW-1:0]   otp_state;
  logic [CW-1:0]   otp_count;
  logic [3:0]      lc_esc;

  int total = 0;
  int bad   = 0;
  int m_last;
  logic [SW-1:0] ps [N];
  logic [CW-1:0] pc [N];

  always #5 clk = ~clk;

  lc_otp_prog_arb #(.NUM_REQ(N), .STATE_W(SW), .CNT_W(CW), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_state_i(req_state), .req_count_i(req_count),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status),
    .otp_req_o(otp_req), .otp_state_o(otp_state), .otp_count_o(otp_count),
    .otp_ack_i(otp_ack), .otp_err_i(otp_err), .lc_escalate_en_i(lc_esc),
    .busy_o(busy), .locked_o(locked), .spurious_ack_o(spurious)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round robin: first valid channel strictly after the last one granted, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_payload();
    for (int i = 0; i < N; i++) begin
      ps[i] = {$urandom, $urandom};
      pc[i] = CW'({$urandom, $urandom});
      req_state[i*SW +: SW] = ps[i];
      req_count[i*CW +: CW] = pc[i];
    end
  endtask

  task automatic do_reset();
    req_valid = '0; otp_ack = 1'b0; otp_err = 1'b0; lc_esc = 4'b1010;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = N - 1;
  endtask

  // Issue a request with mask vm, check the grant, then ack after dly REQ cycles.
  task automatic run_txn(input logic [N-1:0] vm, input int dly, input logic err);
    int g;
    logic [N-1:0] oh;
    set_payload();
    req_valid = vm;
    tick();
    g = pick(vm, m_last);
    m_last = g;
    oh = N'(1 << g);
    total++; if (req_ready !== oh) begin bad++; $display("FAIL grant: req_ready=%b exp=%b", req_ready, oh); end
    total++; if ({otp_req, busy} !== 2'b11) begin bad++; $display("FAIL otp_req_rise: otp_req,busy=%b exp=11", {otp_req, busy}); end
    total++; if (otp_state !== ps[g]) begin bad++; $display("FAIL otp_state: got=%h exp=%h", otp_state, ps[g]); end
    total++; if (otp_count !== pc[g]) begin bad++; $display("FAIL otp_count: got=%h exp=%h", otp_count, pc[g]); end
    for (int i = 0; i < dly; i++) begin
      tick();
      total++;
      if ({otp_req, req_ready, rsp_valid, otp_state} !== {1'b1, N'(0), N'(0), ps[g]}) begin
        bad++; $display("FAIL hold: otp_req=%b ready=%b rsp=%b state=%h", otp_req, req_ready, rsp_valid, otp_state);
      end
    end
    otp_ack = 1'b1; otp_err = err;
    tick();
    otp_ack = 1'b0; otp_err = 1'b0;
    total++; if (rsp_valid !== oh) begin bad++; $display("FAIL rsp_valid: got=%b exp=%b", rsp_valid, oh); end
    total++; if (rsp_status !== {1'b0, err}) begin bad++; $display("FAIL rsp_status: got=%b exp=%b", rsp_status, {1'b0, err}); end
    total++; if ({otp_req, busy} !== 2'b00) begin bad++; $display("FAIL release: otp_req,busy=%b exp=00", {otp_req, busy}); end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_status, otp_req, busy, locked, spurious} !== '0) begin
      bad++; $display("FAIL reset_ctl: ready=%b rsp=%b st=%b req=%b busy=%b lock=%b spur=%b",
                      req_ready, rsp_valid, rsp_status, otp_req, busy, locked, spurious);
    end
    total++; if ({otp_state, otp_count} !== '0) begin bad++; $display("FAIL reset_payload: state=%h count=%h exp=0", otp_state, otp_count); end
  endtask

  task automatic test_basic();
    run_txn(2'b01, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) run_txn(2'b11, 0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int g, n;
    set_payload();
    req_valid = N'($urandom_range(1, (1 << N) - 1));
    tick();
    g = pick(req_valid, m_last);
    m_last = g;
    req_valid = '0;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (otp_req === 1'b0) break;
    end
    total++; if (n !== TMO) begin bad++; $display("FAIL timeout_len: cycles=%0d exp=%0d", n, TMO); end
    total++; if (rsp_valid !== N'(1 << g)) begin bad++; $display("FAIL timeout_rsp: rsp=%b exp=%b", rsp_valid, N'(1 << g)); end
    total++; if (rsp_status !== 2'b10) begin bad++; $display("FAIL timeout_status: got=%b exp=10", rsp_status); end
    run_txn(N'($urandom_range(1, (1 << N) - 1)), 1, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_ack_at_expiry();
    int g;
    set_payload();
    req_valid = 2'b10;
    tick();
    g = pick(req_valid, m_last);
    m_last = g;
    req_valid = '0;
    repeat (TMO - 1) tick();
    total++; if (otp_req !== 1'b1) begin bad++; $display("FAIL pre_expiry: otp_req=%b exp=1", otp_req); end
    otp_ack = 1'b1;
    tick();
    otp_ack = 1'b0;
    total++; if (rsp_valid !== N'(1 << g)) begin bad++; $display("FAIL ack_expiry_rsp: rsp=%b exp=%b", rsp_valid, N'(1 << g)); end
    total++; if (rsp_status !== 2'b00) begin bad++; $display("FAIL ack_expiry_status: got=%b exp=00", rsp_status); end
  endtask

  task automatic test_spurious();
    otp_ack = 1'b1;
    tick();
    otp_ack = 1'b0;
    total++; if (spurious !== 1'b1) begin bad++; $display("FAIL spurious_set: got=%b exp=1", spurious); end
    repeat (3) begin
      tick();
      total++;
      if ({spurious, rsp_valid, otp_req} !== {1'b1, N'(0), 1'b0}) begin
        bad++; $display("FAIL spurious_sticky: spur=%b rsp=%b req=%b", spurious, rsp_valid, otp_req);
      end
    end
  endtask

  task automatic test_reset_mid_req();
    set_payload();
    req_valid = 2'b01;
    tick();
    m_last = pick(req_valid, m_last);
    req_valid = '0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_status, otp_req, busy, locked, spurious} !== '0) begin
      bad++; $display("FAIL async_reset: ready=%b rsp=%b st=%b req=%b busy=%b lock=%b spur=%b",
                      req_ready, rsp_valid, rsp_status, otp_req, busy, locked, spurious);
    end
    total++; if ({otp_state, otp_count} !== '0) begin bad++; $display("FAIL async_reset_payload: state=%h count=%h", otp_state, otp_count); end
    @(negedge clk);
    rst_n = 1'b1;
    m_last = N - 1;
    run_txn(2'b11, 0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_escalate(input logic [3:0] code, input logic with_ack);
    int g;
    set_payload();
    req_valid = N'($urandom_range(1, (1 << N) - 1));
    tick();
    g = pick(req_valid, m_last);
    m_last = g;
    req_valid = '0;
    lc_esc = code;
    repeat (2) begin
      tick();
      total++; if ({otp_req, locked} !== 2'b10) begin bad++; $display("FAIL esc_sync: otp_req,locked=%b exp=10", {otp_req, locked}); end
    end
    if (with_ack) begin otp_ack = 1'b1; otp_err = 1'b1; end
    tick();
    otp_ack = 1'b0; otp_err = 1'b0;
    total++; if ({locked, otp_req, busy} !== 3'b100) begin bad++; $display("FAIL esc_lock: locked,req,busy=%b exp=100", {locked, otp_req, busy}); end
    total++; if (rsp_valid !== N'(1 << g)) begin bad++; $display("FAIL esc_rsp: rsp=%b exp=%b", rsp_valid, N'(1 << g)); end
    total++; if (rsp_status !== 2'b11) begin bad++; $display("FAIL esc_status: got=%b exp=11", rsp_status); end
    req_valid = '1;
    repeat (5) begin
      tick();
      total++;
      if ({req_ready, rsp_valid, otp_req, locked} !== {N'(0), N'(0), 1'b0, 1'b1}) begin
        bad++; $display("FAIL locked_ignore: ready=%b rsp=%b req=%b locked=%b", req_ready, rsp_valid, otp_req, locked);
      end
    end
    req_valid = '0;
    lc_esc = 4'b1010;
  endtask

  initial begin
    req_valid = '0; req_state = '0; req_count = '0;
    otp_ack = 1'b0; otp_err = 1'b0; lc_esc = 4'b1010; rst_n = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_timeout();
    test_ack_at_expiry();
    test_spurious();
    test_reset_mid_req();
    test_escalate(4'b0101, 1'b0);
    do_reset();
    test_escalate(4'b0000, 1'b0);
    do_reset();
    test_escalate(4'b0101, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
